// File: rtl/cntr8_ctrl.sv
// Sequencer for an external 8-bit counter: load a start value, step it n times,
// then check the counter's returned value against the expected sum.
module cntr8_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] d_init,
  input  logic [7:0] n_steps,
  input  logic [7:0] cnt_val,
  output logic       load,
  output logic       inc,
  output logic [7:0] d_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_RUN   = 3'b010,
    S_CHECK = 3'b011,
    S_DONE  = 3'b100
  } state_e;

  typedef struct packed {
    logic [7:0] d_init;
    logic [7:0] n_steps;
  } req_t;

  state_e     state_q, state_d;
  req_t       req_q, req_d;
  logic [7:0] rem_q, rem_d;
  logic       err_q, err_d;
  logic [7:0] exp_sum;

  // Carry out of the 8-bit add is discarded, matching the counter's wrap.
  assign exp_sum = req_q.d_init + req_q.n_steps;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          req_d.d_init  = d_init;
          req_d.n_steps = n_steps;
          rem_d         = n_steps;
          err_d         = 1'b0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort)                    state_d = S_IDLE;
        else if (req_q.n_steps != '0) state_d = S_RUN;
        else                          state_d = S_CHECK;
      end
      S_RUN: begin
        if (abort) state_d = S_IDLE;
        else begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) state_d = S_IDLE;
        else begin
          err_d   = (cnt_val != exp_sum);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Strobes come purely from flops so nothing upstream can glitch the counter.
  assign load    = (state_q == S_LOAD);
  assign inc     = (state_q == S_RUN);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign d_in    = req_q.d_init;
  assign o_state = state_q;

endmodule
